av_config_initiator: RTL and testbench
======================================

Name: av_config_initiator

Overview:
- Avalon-MM master that drives the audio/video config core's slave port (av_config_slave_*) to program the codec after reset or on software request.
- Walks a parameterised command table: one write per entry, then polls a status register until the core reports idle, with a timeout.
- Sits beside software_interface and replaces its tied-off av_config_slave_* stubs with real traffic.
- Status is exported to software_interface, which exposes it as readable flags.

Parameters:
- NUM_CMDS, 3, number of table entries (1..16).
- CMD_TABLE, {2'd3,32'h0000_001F, 2'd2,32'h0000_0004, 2'd0,32'h0000_0001}, packed table; entry i = bits [34*i+33:34*i] = {addr[1:0], data[31:0]}; entry 0 in the LSBs (rightmost), so default entry 0 = {0, 0x00000001}, entry 1 = {2, 0x00000004}, entry 2 = {3, 0x0000001F}.
- STATUS_ADDR, 1, word address of the config core's status register.
- POLL_BIT, 0, status bit that reads 1 while the core is busy.
- TIMEOUT, 1023, maximum poll reads per entry before error.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a sequence when idle
- av_config_slave_address  output  2  Avalon word address
- av_config_slave_byteenable  output  4  byte enables
- av_config_slave_read  output  1  read request
- av_config_slave_write  output  1  write request
- av_config_slave_writedata  output  32  write data
- av_config_slave_readdata  input  32  read data, valid when read=1 and waitrequest=0
- av_config_slave_waitrequest  input  1  slave stall
- busy  output  1  sequence in progress
- done  output  1  sticky; last sequence completed cleanly
- error  output  1  sticky; last sequence hit a poll timeout
- cmd_index  output  4  entry currently being processed

Behaviour:
- Reset values: all av_config_slave_* outputs 0, busy=0, done=0, error=0, cmd_index=0, state IDLE.
- Reset asserted mid-transfer: the bus is dropped on the next edge. The next start restarts the sequence from entry 0.
- Avalon rules:
  - A request (read or write) is held with address/writedata/byteenable stable until the cycle in which waitrequest=0. That cycle completes the transfer.
  - Read data is captured in the same cycle the read completes; there is no readdatavalid.
  - read and write are never both 1.
  - byteenable = 4'hF whenever read or write is 1, else 0.
- States:
  - IDLE:
    - start=1 -> WRITE. Same edge: clear done and error, set busy=1, cmd_index=0, poll counter=0.
    - start while not IDLE is ignored.
  - WRITE:
    - Drive write=1, address/writedata from entry cmd_index.
    - On a cycle with waitrequest=0: deassert write next cycle, clear poll counter, go to POLL.
  - POLL:
    - Drive read=1, address=STATUS_ADDR.
    - On a completing cycle with readdata[POLL_BIT]=0: if cmd_index==NUM_CMDS-1 go to IDLE with busy=0 and done=1; else increment cmd_index and go to WRITE.
    - On a completing cycle with bit=1: increment the poll counter. When the counter reaches TIMEOUT, go to IDLE with busy=0 and error=1, leaving cmd_index at the failing entry. Otherwise issue a new read.
- Back-to-back transfers:
  - Between any two transfers, read and write are both 0 for exactly one cycle.
  - Minimum latency per entry, with no stalls and an idle status: write 1 cycle + gap 1 + read 1 + gap 1 = 4 cycles.
- Whole sequence timing: busy rises on the edge after start. done rises 4*NUM_CMDS cycles after busy rises, with no stalls (12 cycles for the default table).
- done/error are mutually exclusive and persist until the next accepted start.

Test Plan:
- Default table, waitrequest=0, readdata=0; pulse start -> writes (0,0x1),(2,0x4),(3,0x1F), each followed by one read of addr 1; done=1 at 12 cycles after busy rises; error=0.
- waitrequest held 1 for 5 cycles on entry 1's write -> write, address=2, writedata=0x4 stable for all 6 cycles; single write accepted; sequence completes, done=1 at 17 cycles after busy rises.
- readdata[0]=1 for the first 3 status reads of entry 0 -> 4 reads issued, each separated by one idle cycle, then write of entry 1; done=1.
- readdata[0] stuck at 1 with TIMEOUT=8 -> exactly 8 reads on entry 0, then error=1, busy=0, done=0, cmd_index=0; no further bus activity.
- start pulsed during busy -> ignored, sequence unchanged. Reset asserted mid-write -> write=0 next cycle, all outputs at reset values; a new start replays from entry 0.
- After an error, a new start with readdata=0 -> error clears on the start edge and done=1 at completion.

Source files
------------

// File: rtl/av_config_initiator.sv
// av_config_initiator: Avalon-MM master that replays a codec command table into the
// audio/video config core, polling its status register until idle after every write.
module av_config_initiator #(
    parameter int NUM_CMDS = 3,
    parameter logic [34*NUM_CMDS-1:0] CMD_TABLE = {2'd3, 32'h0000_001F, 2'd2, 32'h0000_0004, 2'd0, 32'h0000_0001},
    parameter logic [1:0] STATUS_ADDR = 2'd1,
    parameter int POLL_BIT = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [1:0]  av_config_slave_address,
    output logic [3:0]  av_config_slave_byteenable,
    output logic        av_config_slave_read,
    output logic        av_config_slave_write,
    output logic [31:0] av_config_slave_writedata,
    input  logic [31:0] av_config_slave_readdata,
    input  logic        av_config_slave_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  cmd_index
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, WRITE, WGAP, POLL, RGAP} state_t;
    state_t state_q;
    logic [CW-1:0] poll_cnt_q;
    logic [3:0] cmd_index_q;
    logic [1:0] address_q;
    logic [31:0] writedata_q;
    logic read_q, write_q, busy_q, done_q, error_q, status_busy_q;
    logic [3:0] next_index;
    logic [33:0] next_entry;
    logic unused_readdata;
    assign next_index = cmd_index_q + 4'd1;
    assign next_entry = CMD_TABLE[34*next_index +: 34];
    assign unused_readdata = ^av_config_slave_readdata;
    // Each completed transfer passes through a one-cycle gap state before the next request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            poll_cnt_q    <= '0;
            cmd_index_q   <= '0;
            address_q     <= '0;
            writedata_q   <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            status_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q     <= WRITE;
                    write_q     <= 1'b1;
                    address_q   <= CMD_TABLE[33:32];
                    writedata_q <= CMD_TABLE[31:0];
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                    error_q     <= 1'b0;
                    cmd_index_q <= '0;
                    poll_cnt_q  <= '0;
                end
                WRITE: if (!av_config_slave_waitrequest) begin
                    state_q    <= WGAP;
                    write_q    <= 1'b0;
                    poll_cnt_q <= '0;
                end
                WGAP: begin
                    state_q   <= POLL;
                    read_q    <= 1'b1;
                    address_q <= STATUS_ADDR;
                end
                POLL: if (!av_config_slave_waitrequest) begin
                    state_q       <= RGAP;
                    read_q        <= 1'b0;
                    status_busy_q <= av_config_slave_readdata[POLL_BIT];
                    if (av_config_slave_readdata[POLL_BIT]) poll_cnt_q <= poll_cnt_q + 1'b1;
                end
                RGAP: begin
                    if (!status_busy_q && cmd_index_q == 4'(NUM_CMDS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (!status_busy_q) begin
                        state_q     <= WRITE;
                        write_q     <= 1'b1;
                        cmd_index_q <= next_index;
                        address_q   <= next_entry[33:32];
                        writedata_q <= next_entry[31:0];
                    end else if (poll_cnt_q == CW'(TIMEOUT)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        state_q <= POLL;
                        read_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign av_config_slave_address    = address_q;
    assign av_config_slave_byteenable = {4{read_q | write_q}};
    assign av_config_slave_read       = read_q;
    assign av_config_slave_write      = write_q;
    assign av_config_slave_writedata  = writedata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cmd_index = cmd_index_q;
endmodule

// File: tb/tb_av_config_initiator.sv
// tb_av_config_initiator: table-driven and randomized scenarios against a stalling Avalon
// slave model; expected transfers and timing come from per-entry cycle arithmetic.
module tb_av_config_initiator;
    localparam int T = 8;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0] addr;
    logic [3:0] be, idx;
    logic rd, wr, waitreq = 1'b0, busy, done, error;
    logic [31:0] wdata, rdata = '0;
    int cyc = 0;
    int checks = 0, failures = 0;

    av_config_initiator #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .start(start),
        .av_config_slave_address(addr), .av_config_slave_byteenable(be),
        .av_config_slave_read(rd), .av_config_slave_write(wr),
        .av_config_slave_writedata(wdata), .av_config_slave_readdata(rdata),
        .av_config_slave_waitrequest(waitreq),
        .busy(busy), .done(done), .error(error), .cmd_index(idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {bit w; logic [1:0] a; logic [31:0] d;} tr_t;
    typedef struct {int w0, w1, w2, b0, b1, b2, rs; bit mid; int cyc; bit dn, er; int ix;} vec_t;
    tr_t log_q[$], exp_q[$];
    logic [1:0] tbl_a[3] = '{2'd0, 2'd2, 2'd3};
    logic [31:0] tbl_d[3] = '{32'h1, 32'h4, 32'h1F};
    int ws_a[3], br_a[3], rs_v;
    int stall, wr_cnt, rd_cnt, idle_run, prot_err;
    bit in_req, have_prev, req_wr;
    logic [1:0] req_addr;
    logic [31:0] req_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: per-request stall counts, status busy for the first br_a[entry] reads.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            in_req = 0;
            waitreq = 0;
            rdata = $urandom;
        end else begin
            if (rd && wr) prot_err++;
            if (be !== ((rd || wr) ? 4'hF : 4'h0)) prot_err++;
            if (rd || wr) begin
                if (!in_req) begin
                    if (have_prev && idle_run != 1) prot_err++;
                    in_req = 1;
                    stall = wr ? ((wr_cnt < 3) ? ws_a[wr_cnt] : 0) : rs_v;
                    req_addr = addr;
                    req_data = wdata;
                    req_wr = wr;
                end else if (addr !== req_addr || wr !== req_wr || (wr && wdata !== req_data)) prot_err++;
                idle_run = 0;
                waitreq = (stall > 0);
                rdata = $urandom;
                if (stall > 0) stall--;
                else begin
                    in_req = 0;
                    have_prev = 1;
                    log_q.push_back('{wr, addr, wr ? wdata : 32'd0});
                    if (wr) begin
                        wr_cnt++;
                        rd_cnt = 0;
                    end else begin
                        rdata[0] = (wr_cnt > 0 && wr_cnt <= 3) ? (rd_cnt < br_a[wr_cnt-1]) : 1'b0;
                        rd_cnt++;
                    end
                end
            end else begin
                idle_run++;
                waitreq = 1'($urandom_range(0, 1));
                rdata = $urandom;
            end
        end
    end

    function automatic vec_t mk(int w0, w1, w2, b0, b1, b2, rs, bit mid, int c, bit dn, er, int ix);
        vec_t v;
        v.w0 = w0; v.w1 = w1; v.w2 = w2; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.rs = rs; v.mid = mid; v.cyc = c; v.dn = dn; v.er = er; v.ix = ix;
        return v;
    endfunction

    task automatic run(input vec_t v);
        int ecyc, eidx, t0, n, bad;
        bit edone, eerr;
        ws_a = '{v.w0, v.w1, v.w2};
        br_a = '{v.b0, v.b1, v.b2};
        rs_v = v.rs;
        exp_q.delete();
        ecyc = 0; eidx = 0; edone = 0; eerr = 0;
        for (int k = 0; k < 3; k++) begin
            int nr;
            exp_q.push_back('{1'b1, tbl_a[k], tbl_d[k]});
            nr = (br_a[k] >= T) ? T : br_a[k] + 1;
            for (int j = 0; j < nr; j++) exp_q.push_back('{1'b0, 2'd1, 32'd0});
            ecyc += ws_a[k] + 2 + nr * (rs_v + 2);
            eidx = k;
            if (br_a[k] >= T) begin
                eerr = 1;
                break;
            end
            if (k == 2) edone = 1;
        end
        if (v.cyc >= 0) begin
            ecyc = v.cyc; edone = v.dn; eerr = v.er; eidx = v.ix;
        end
        log_q.delete();
        have_prev = 0; wr_cnt = 0; rd_cnt = 0; prot_err = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        t0 = cyc;
        chk("start_flags", {busy, done, error}, 3'b100);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            if (v.mid) start = (cyc == t0 + 5);
            n++;
        end
        start = 0;
        if (n >= 2000) chk("busy_timeout", 1, 0);
        chk("latency", cyc - t0, ecyc);
        chk("done", done, edone);
        chk("error", error, eerr);
        chk("cmd_index", idx, eidx);
        repeat (6) @(negedge clk);
        chk("quiet_after", {busy, rd, wr}, 0);
        chk("log_size", log_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            if (log_q[i] != exp_q[i]) bad++;
        chk("log_content", bad, 0);
        chk("protocol", prot_err, 0);
    endtask

    initial begin
        vec_t vecs[$];
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 1, 0, 2));
        vecs.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 17, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 18, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 99, 0, 0, 0, 0, 18, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8, 0, 0, 26, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 7, 0, 0, 26, 1, 0, 2));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 2, 0, 21, 1, 0, 2));
        for (int i = 0; i < 12; i++)
            vecs.push_back(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                              $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1, 0, 0, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {wr, rd, be, addr, wdata, busy, done, error, idx}, 0);
        reset = 0;
        ws_a = '{10, 0, 0};
        br_a = '{0, 0, 0};
        rs_v = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        chk("write_before_reset", {wr, addr, wdata}, {1'b1, 2'd0, 32'h1});
        reset = 1;
        @(negedge clk);
        chk("mid_reset_state", {wr, rd, be, addr, wdata, busy, done, error, idx}, 0);
        reset = 0;
        foreach (vecs[i]) run(vecs[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
